// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcodes (also used by instruction_decoder) and datapath select encodings.
// Pure constants and one helper function; no logic of its own.
package cpu_ctrl_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_MEM    = 3'd4;
    localparam state_t ST_WB     = 3'd5;
    localparam state_t ST_HALTED = 3'd6;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000001;
    localparam logic [5:0] OP_LD    = 6'b001000;
    localparam logic [5:0] OP_ST    = 6'b001001;
    localparam logic [5:0] OP_BR    = 6'b001010;
    localparam logic [5:0] OP_BZ    = 6'b001011;
    localparam logic [5:0] OP_CALL  = 6'b001100;
    localparam logic [5:0] OP_MOVE  = 6'b010010;
    localparam logic [5:0] OP_HALT  = 6'b010110;
    localparam logic [5:0] OP_NOP   = 6'b010111;
    localparam logic [5:0] OP_RET   = 6'b011000;

    // PC source select
    localparam logic [1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_MEM    = 2'd2;

    // Writeback source select
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;

    // ALU operation mode
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_FUNCT = 2'd1;
    localparam logic [1:0] ALU_SUB   = 2'd2;

    // True for every opcode the control unit knows how to sequence.
    function automatic logic opcode_known(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LD, OP_ST, OP_BR, OP_BZ,
            OP_CALL, OP_MOVE, OP_HALT, OP_NOP, OP_RET: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits without a ready response.
// expired is combinational and rises in the MEM_TIMEOUT-th unanswered cycle.
// No backpressure; counter clears whenever req is low or ready is high.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count unanswered request cycles, saturating at the last allowed cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!req || ready) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CW'(1);
        end
    end

    // A request still unanswered in its final allowed cycle is a bus error.
    assign expired = req && !ready && (count == LAST);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency per instruction 2..5 cycles with mem_ready high; +1 per wait cycle.
// Memory backpressure via mem_ready holds FETCH/MEM; bounded by a bus timeout.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_imm,
    output logic [1:0]       alu_mode,
    output logic             sp_inc,
    output logic             sp_dec,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired
);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] op_q;
    logic       retire_inc;
    logic       expired;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .req     (mem_req),
        .ready   (mem_ready),
        .expired (expired)
    );

    // Next-state selection and retirement detection.
    always_comb begin
        state_nxt  = state;
        retire_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (expired)        state_nxt = ST_HALTED;
                else if (mem_ready) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                // Decide on the live opcode; op_q only becomes valid next cycle.
                if (opcode == OP_HALT) begin
                    state_nxt  = ST_HALTED;
                    retire_inc = 1'b1;
                end else if (opcode == OP_NOP || !opcode_known(opcode)) begin
                    state_nxt  = ST_FETCH;
                    retire_inc = 1'b1;
                end else begin
                    state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LD, OP_ST, OP_CALL, OP_RET: state_nxt = ST_MEM;
                    OP_BR, OP_BZ: begin
                        state_nxt  = ST_FETCH;
                        retire_inc = 1'b1;
                    end
                    default: state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (expired) begin
                    state_nxt = ST_HALTED;
                end else if (mem_ready) begin
                    if (op_q == OP_LD) begin
                        state_nxt = ST_WB;
                    end else begin
                        state_nxt  = ST_FETCH;
                        retire_inc = 1'b1;
                    end
                end
            end
            ST_WB: begin
                state_nxt  = ST_FETCH;
                retire_inc = 1'b1;
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State, latched opcode, sticky bus error and retired counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            bus_error <= 1'b0;
            retired   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) op_q <= opcode;
            if (expired)            bus_error <= 1'b1;
            if (retire_inc)         retired <= retired + CNT_W'(1);
        end
    end

    // Datapath strobes decoded from state, op_q, zero and mem_ready.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = PC_SEL_PC4;
        reg_write   = 1'b0;
        wb_sel      = WB_SEL_ALU;
        alu_src_imm = 1'b0;
        alu_mode    = ALU_ADD;
        sp_inc      = 1'b0;
        sp_dec      = 1'b0;
        illegal_op  = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_sel   = PC_SEL_PC4;
                end
            end
            ST_DECODE: begin
                illegal_op = !opcode_known(opcode);
            end
            ST_EXEC: begin
                case (op_q)
                    OP_RTYPE: alu_mode = ALU_FUNCT;
                    // MOVE relies on the decoder presenting imm = 0.
                    OP_ADDI, OP_MOVE, OP_LD, OP_ST: alu_src_imm = 1'b1;
                    OP_BR: begin
                        pc_write = 1'b1;
                        pc_sel   = PC_SEL_BRANCH;
                    end
                    OP_BZ: begin
                        alu_mode = ALU_SUB;
                        if (zero) begin
                            pc_write = 1'b1;
                            pc_sel   = PC_SEL_BRANCH;
                        end
                    end
                    OP_CALL: sp_dec = 1'b1;
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_ST) || (op_q == OP_CALL);
                if (mem_ready) begin
                    if (op_q == OP_CALL) begin
                        pc_write = 1'b1;
                        pc_sel   = PC_SEL_BRANCH;
                    end else if (op_q == OP_RET) begin
                        pc_write = 1'b1;
                        pc_sel   = PC_SEL_MEM;
                        sp_inc   = 1'b1;
                    end
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = (op_q == OP_LD) ? WB_SEL_MEM : WB_SEL_ALU;
            end
            default: ;
        endcase
    end

    assign halted = (state == ST_HALTED);

endmodule
